bridge_request_arbiter: RTL and testbench
=========================================

// Module: bridge_request_arbiter
// PURPOSE
//  Shares the single core->host request channel of the bridge command driver among N core clients.
//  Grants one client at a time and holds the grant from offer through completion.
//  Routes ack/done back to the granted client; progress/result/response are broadcast.
//  Sits between core-side command sources and the driver's request port.
// PARAMETERS
//  N_CLIENTS   4    number of requesters, 2..8
//  IDX_W       $clog2(N_CLIENTS)  grant index width (derived, not overridable)
// PORTS
//  clk           in   1         bridge clock; all logic on posedge
//  reset         in   1         synchronous, active-high
//  req_valid     in   N         client i command valid; held until req_ack[i]
//  req_word      in   N*16      client i command word (slice i*16 +: 16)
//  req_param     in   N*128     client i parameters (slice i*128 +: 128)
//  req_ack       out  N         one-hot; client i command accepted
//  req_done      out  N         one-hot pulse; client i command complete
//  req_progress  out  16        broadcast progress (= m_progress)
//  req_result    out  16        broadcast result (= m_result)
//  req_response  out  128       broadcast response (= m_response)
//  m_valid       out  1         to driver: command valid
//  m_word        out  16        to driver: command word
//  m_param       out  128       to driver: parameters
//  m_ack         in   1         from driver: accepted
//  m_progress    in   16        from driver
//  m_done        in   1         from driver: one-cycle completion pulse
//  m_result      in   16        from driver
//  m_response    in   128       from driver
//  busy          out  1         state != IDLE
//  grant_idx     out  IDX_W     currently/last granted client
// BEHAVIOUR
//  Reset: state=IDLE, grant_idx=0, rr_last=N-1; m_valid=0, req_ack=0, req_done=0, busy=0.
//  States: IDLE -> OFFER -> BUSY -> IDLE.
//  IDLE: if any req_valid, register winner into grant_idx, go OFFER (m_valid rises next cycle).
//   No combinational path from req_valid to m_valid; minimum 1 cycle arbitration latency.
//  OFFER: m_valid=req_valid[grant]; m_word/m_param muxed combinationally from granted client.
//   req_ack[grant]=m_ack (same cycle). On m_ack go BUSY, rr_last<=grant_idx.
//   Granted client drops valid before ack (protocol violation): return to IDLE, no ack, no done.
//  BUSY: m_valid=0. req_done[grant]=m_done (same cycle); on m_done go IDLE.
//   Next arbitration happens in the IDLE cycle following done: back-to-back grants are 2 cycles apart.
//  m_done outside BUSY is ignored: no req_done, no state change.
//  m_ack outside OFFER is ignored.
//  Round-robin: search starts at rr_last+1 mod N and wraps; rr_last updates only on ack.
//  Non-granted clients' req_valid is never acked and is not disturbed; they wait.
//  req_progress/result/response pass through unregistered; only the granted client may sample them.
//  Reset mid-operation: returns to IDLE at once; a later m_done from the orphaned command is ignored.
//  m_word/m_param are don't-care when m_valid=0 (drive granted client's values).
// CONFIGURATION
//  BRIDGE_ARB_FIXED_PRIORITY_EN defined: fixed priority, lowest index wins; rr_last unused.
//  Not defined (default): round-robin as above.
//  All other behaviour is identical with or without the macro.
// TESTING
//  Single client 1 valid, m_ack 2 cycles later, m_done 5 later -> req_ack[1] and req_done[1] pulse; busy 0 after.
//  Clients 0,2,3 valid together, driver acks/dones each -> grant order 0,2,3 (RR); with macro also 0,2,3.
//  Client 0 re-requests continuously with client 1 valid -> RR alternates 0,1,0,1; with macro 0 starves 1.
//  Client 2 drops valid in OFFER -> m_valid falls, FSM in IDLE next cycle, no req_ack/req_done.
//  Stray m_done while IDLE -> no req_done; reset asserted in BUSY -> IDLE, subsequent m_done ignored.
//  Client 3 word 16'h1234, param 128'hA5.. -> m_word/m_param match exactly while m_valid=1.

Source files
------------

// File: rtl/bridge_request_arbiter.sv
// rtl/bridge_request_arbiter.sv - N-client arbiter for the bridge command driver request channel.
// Define BRIDGE_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins); default is round-robin.
module bridge_request_arbiter #(
    parameter int N_CLIENTS = 4,
    localparam int IDX_W = $clog2(N_CLIENTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CLIENTS-1:0]     req_valid,
    input  logic [N_CLIENTS*16-1:0]  req_word,
    input  logic [N_CLIENTS*128-1:0] req_param,
    output logic [N_CLIENTS-1:0]     req_ack,
    output logic [N_CLIENTS-1:0]     req_done,
    output logic [15:0]              req_progress,
    output logic [15:0]              req_result,
    output logic [127:0]             req_response,
    output logic                     m_valid,
    output logic [15:0]              m_word,
    output logic [127:0]             m_param,
    input  logic                     m_ack,
    input  logic [15:0]              m_progress,
    input  logic                     m_done,
    input  logic [15:0]              m_result,
    input  logic [127:0]             m_response,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic             granted_valid;

`ifndef BRIDGE_ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0] rr_last_q, rr_last_d;
`endif

    assign any_valid     = |req_valid;
    assign granted_valid = req_valid[grant_q];

`ifdef BRIDGE_ARB_FIXED_PRIORITY_EN
    // Descending scan so the lowest requesting index is the last one to overwrite.
    always_comb begin
        winner = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (req_valid[IDX_W'(i)]) begin
                winner = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        logic found;
        logic [IDX_W-1:0] cand;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            cand = IDX_W'((int'(rr_last_q) + k) % N_CLIENTS);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifndef BRIDGE_ARB_FIXED_PRIORITY_EN
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d = winner;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // A client withdrawing before acceptance simply forfeits its grant.
                if (!granted_valid) begin
                    state_d = IDLE;
                end else if (m_ack) begin
                    state_d = BUSY;
`ifndef BRIDGE_ARB_FIXED_PRIORITY_EN
                    rr_last_d = grant_q;
`endif
                end
            end
            BUSY: begin
                if (m_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
`ifndef BRIDGE_ARB_FIXED_PRIORITY_EN
            rr_last_q <= IDX_W'(N_CLIENTS - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifndef BRIDGE_ARB_FIXED_PRIORITY_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    always_comb begin
        req_ack  = '0;
        req_done = '0;
        req_ack[grant_q]  = (state_q == OFFER) && granted_valid && m_ack;
        req_done[grant_q] = (state_q == BUSY) && m_done;
    end

    assign m_valid      = (state_q == OFFER) && granted_valid;
    assign m_word       = req_word[grant_q*16 +: 16];
    assign m_param      = req_param[grant_q*128 +: 128];
    assign req_progress = m_progress;
    assign req_result   = m_result;
    assign req_response = m_response;
    assign busy         = (state_q != IDLE);
    assign grant_idx    = grant_q;

endmodule

// File: tb/tb_bridge_request_arbiter.sv
// tb/tb_bridge_request_arbiter.sv - directed self-checking bench for bridge_request_arbiter.
module tb_bridge_request_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [63:0]  req_word;
    logic [511:0] req_param;
    logic [3:0]   req_ack;
    logic [3:0]   req_done;
    logic [15:0]  req_progress;
    logic [15:0]  req_result;
    logic [127:0] req_response;
    logic         m_valid;
    logic [15:0]  m_word;
    logic [127:0] m_param;
    logic         m_ack;
    logic [15:0]  m_progress;
    logic         m_done;
    logic [15:0]  m_result;
    logic [127:0] m_response;
    logic         busy;
    logic [1:0]   grant_idx;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bridge_request_arbiter #(.N_CLIENTS(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_word(req_word), .req_param(req_param),
        .req_ack(req_ack), .req_done(req_done),
        .req_progress(req_progress), .req_result(req_result), .req_response(req_response),
        .m_valid(m_valid), .m_word(m_word), .m_param(m_param), .m_ack(m_ack),
        .m_progress(m_progress), .m_done(m_done), .m_result(m_result), .m_response(m_response),
        .busy(busy), .grant_idx(grant_idx)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Entered in IDLE with requests already driven; leaves in IDLE after done.
    task automatic do_txn(input int exp_g, input logic keep);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << exp_g;
        tick();
        chk($sformatf("grant_%0d", exp_g), 128'(grant_idx), 128'(exp_g));
        chk("offer_m_valid", 128'(m_valid), 128'(1));
        m_ack = 1'b1;
        #1;
        chk("offer_req_ack", 128'(req_ack), 128'(one_hot));
        tick();
        m_ack = 1'b0;
        if (!keep) req_valid[exp_g] = 1'b0;
        #1;
        chk("busy_m_valid", 128'(m_valid), 128'(0));
        chk("busy_flag", 128'(busy), 128'(1));
        m_done = 1'b1;
        #1;
        chk("busy_req_done", 128'(req_done), 128'(one_hot));
        tick();
        m_done = 1'b0;
        #1;
        chk("after_done_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; m_ack = 1'b0; m_done = 1'b0;
        req_word = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        req_param = '0;
        m_progress = '0; m_result = '0; m_response = '0;
        do_reset();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_grant", 128'(grant_idx), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_req_ack", 128'(req_ack), 128'(0));
        chk("rst_req_done", 128'(req_done), 128'(0));

        // Single client 1: ack two cycles into the offer, done five cycles into busy.
        req_valid = 4'b0010;
        #1;
        chk("no_comb_m_valid", 128'(m_valid), 128'(0));
        tick();
        chk("c1_grant", 128'(grant_idx), 128'(1));
        chk("c1_m_valid", 128'(m_valid), 128'(1));
        chk("c1_no_early_ack", 128'(req_ack), 128'(0));
        tick();
        m_ack = 1'b1;
        #1;
        chk("c1_ack", 128'(req_ack), 128'(4'b0010));
        tick();
        m_ack = 1'b0; req_valid = '0;
        repeat (4) tick();
        chk("c1_busy_wait", 128'(busy), 128'(1));
        chk("c1_no_early_done", 128'(req_done), 128'(0));
        m_done = 1'b1;
        #1;
        chk("c1_done", 128'(req_done), 128'(4'b0010));
        tick();
        m_done = 1'b0;
        #1;
        chk("c1_idle_after", 128'(busy), 128'(0));

        // Three simultaneous requesters from a fresh reset.
        do_reset();
        req_valid = 4'b1101;
        do_txn(0, 1'b0);
        do_txn(2, 1'b0);
        do_txn(3, 1'b0);

        // Client 0 re-requests continuously against client 1.
        do_reset();
        req_valid = 4'b0011;
        do_txn(0, 1'b1);
        do_txn(1, 1'b1);
        do_txn(0, 1'b1);
        do_txn(1, 1'b1);
        req_valid = '0;
        tick();

        // Client 2 withdraws during the offer.
        do_reset();
        req_valid = 4'b0100;
        tick();
        chk("wd_grant", 128'(grant_idx), 128'(2));
        chk("wd_m_valid_hi", 128'(m_valid), 128'(1));
        req_valid = '0;
        #1;
        chk("wd_m_valid_lo", 128'(m_valid), 128'(0));
        chk("wd_no_ack", 128'(req_ack), 128'(0));
        tick();
        chk("wd_idle", 128'(busy), 128'(0));
        m_ack = 1'b1;
        #1;
        chk("idle_ack_ignored", 128'(req_ack), 128'(0));
        tick();
        m_ack = 1'b0;
        chk("idle_ack_no_state", 128'(busy), 128'(0));

        // Stray done while idle.
        m_done = 1'b1;
        #1;
        chk("stray_done", 128'(req_done), 128'(0));
        tick();
        m_done = 1'b0;
        chk("stray_done_idle", 128'(busy), 128'(0));

        // Reset while busy orphans the outstanding command.
        req_valid = 4'b1000;
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0; req_valid = '0;
        chk("orph_busy", 128'(busy), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("orph_rst_busy", 128'(busy), 128'(0));
        chk("orph_rst_grant", 128'(grant_idx), 128'(0));
        m_done = 1'b1;
        #1;
        chk("orph_done_ignored", 128'(req_done), 128'(0));
        tick();
        m_done = 1'b0;
        chk("orph_still_idle", 128'(busy), 128'(0));

        // Client 3 payload routing and broadcast pass-through.
        req_word = {16'h1234, 16'hBEEF, 16'hCAFE, 16'hF00D};
        req_param = {{16{8'hA5}}, {16{8'h11}}, {16{8'h22}}, {16{8'h33}}};
        req_valid = 4'b1000;
        tick();
        chk("pl_m_valid", 128'(m_valid), 128'(1));
        chk("pl_m_word", 128'(m_word), 128'(16'h1234));
        chk("pl_m_param", m_param, {16{8'hA5}});
        m_progress = 16'h0042; m_result = 16'hD00D; m_response = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #1;
        chk("pt_progress", 128'(req_progress), 128'(16'h0042));
        chk("pt_result", 128'(req_result), 128'(16'hD00D));
        chk("pt_response", req_response, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
